stopwatch_disp_scheduler: RTL and testbench
===========================================

Name: stopwatch_disp_scheduler

Overview:
- Time-multiplexes the six 5-bit stopwatch digit words (in0..in5) onto one shared 6-anode, 8-segment common-anode display.
- Sequences the digit scan with a refresh counter and snapshots inputs once per frame, so a display frame never tears.
- Adds leading-zero blanking and a blink mode, used to show the paused (go=0) state.
- Sits between Enhanced_Stopwatch and the board display pins.

Parameters:
- CLK_PER_DIGIT, 100000, clocks each digit slot is held (1 ms at 100 MHz); minimum 2.
- BLINK_FRAMES, 83, full frames per blink half-period (about 0.5 s at 6 ms/frame); minimum 1.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst_n  in  1  asynchronous active-low reset.
- in0..in5  in  5 each  digit words; bit4 = decimal point, bits3:0 = glyph value 0-F; in0 is the rightmost digit.
- blank_lz  in  1  1 = blank leading zeros.
- blink_en  in  1  1 = blink the whole display.
- an  out  6  anode enables, active-low; an[k] drives digit k.
- sseg  out  8  segments, active-low; sseg[7] = ~dp, sseg[6:0] = g..a.
- frame_tick  out  1  one-cycle pulse at each frame start.

Behaviour:
- Reset (async, rst_n=0): cnt=0, sel=0, shadow words=0, blink_cnt=0, blink_phase=0, an=6'h3F, sseg=8'hFF, frame_tick=0.
- Refresh counter: cnt counts 0..CLK_PER_DIGIT-1.
  - At the terminal count, cnt returns to 0 and sel advances 0→1→…→5→0.
  - A frame is 6*CLK_PER_DIGIT clocks.
- Frame start is the edge where sel wraps 5→0 and cnt→0. At that edge:
  - Shadow registers capture in0..in5.
  - frame_tick is registered high for exactly that next cycle.
  - blink_cnt advances; at BLINK_FRAMES-1 it returns to 0 and blink_phase toggles.
- First frame after reset displays zero shadows, so all digits show "0", or are blanked if blank_lz=1.
- Input-to-display latency: an in* change is shown starting at the next frame start, plus one clock.
- Leading-zero blanking, evaluated on the shadows:
  - Scan from digit 5 downward. A digit is blanked while every digit above it, and the digit itself, has value==0 and dp==0.
  - The first digit that is nonzero or has dp=1 stops blanking.
  - Digit 0 is never blanked.
  - blank_lz is sampled live every cycle.
- Output register, updated every clock from the current cnt, sel, shadows and flags:
  - an <= 6'h3F if cnt==0 (anti-ghost guard cycle), or the digit is blanked, or (blink_en && blink_phase); otherwise an <= ~(6'b1 << sel).
  - sseg <= {~dp, glyph(value)} of shadow[sel], always updated even when the anodes are off.
  - Result: the anode is low for CLK_PER_DIGIT-1 cycles per slot, lagging sel/cnt by one clock.
- Glyphs (g..a, active-low): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
- blink_en=0: blink_phase keeps running but does not mask anodes; the display is never blank because of blink.
- Reset mid-frame: all state returns to reset values immediately; the scan restarts at digit 0 after rst_n deasserts.
- Only one-hot-low or all-high values ever appear on an.

Decomposition:
- Package stopwatch_disp_pkg holds:
  - NUM_DIGITS=6
  - AN_OFF=6'h3F
  - SSEG_OFF=8'hFF
  - the 16-entry glyph constant table
- Sub-module: sseg_decoder. It is combinational: 5-bit word in, 8-bit active-low sseg out.

Test Plan:
1. Scan order (CLK_PER_DIGIT=4, BLINK_FRAMES=2): release reset with in0..in5=5'h00..05 and blank_lz=0. Required response: in each 4-clock slot, an=3F for 1 clock, then ~(1<<k) for 3 clocks, k=0..5. sseg in slot k=glyph(k), e.g. slot 3 → 8'hB0. frame_tick pulses every 24 clocks.
2. Tear-free: change in3 from 5'h03 to 5'h08 while sel=1. Required response: slot 3 still shows 8'hB0 this frame and 8'h80 next frame.
3. Leading-zero blanking: in5..in0=0,0,0,1,2,3 with blank_lz=1. Required response: an[5:3] stay high all frame; digits 2..0 are shown. Then set in5=5'h10 (dp only). Required response: digit 5 shows sseg=8'h40 and digits 4,3 show 8'hC0.
4. Blink: blink_en=1, BLINK_FRAMES=2. Required response: an is all-high for 2 frames, then active for 2 frames, repeating. With blink_en=0, an is never all-high for a whole slot.
5. Decimal point: in2=5'h15. Required response: slot 2 sseg=8'h12. in2=5'h05 gives 8'h92.
6. Async reset mid-slot (sel=4, cnt=2): pulse rst_n low for 3 ns off-edge. Required response: an=3F and sseg=FF immediately; after release the scan restarts at slot 0 and shows zero shadows until the next frame start.

Source files
------------

// File: rtl/stopwatch_disp_pkg.sv
// stopwatch_disp_pkg
//   Shared constants and types for the stopwatch display scheduler:
//   digit count, all-off anode/segment patterns, the active-low glyph
//   table and a helper that turns a 5-bit digit word into segment bits.
package stopwatch_disp_pkg;

   localparam int         NUM_DIGITS = 6;
   localparam logic [5:0] AN_OFF     = 6'h3F;
   localparam logic [7:0] SSEG_OFF   = 8'hFF;

   // Segments g..a, active-low, indexed by glyph value 0-F.
   localparam logic [6:0] GLYPH_TAB [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   // Digit word layout: bit4 = decimal point, bits3:0 = glyph value.
   typedef struct packed {
      logic       dp;
      logic [3:0] val;
   } digit_t;

   function automatic logic [7:0] digit_to_sseg(input digit_t d);
      return {~d.dp, GLYPH_TAB[d.val]};
   endfunction

endpackage

// File: rtl/stopwatch_disp_scheduler_sseg_decoder.sv
// sseg_decoder
//   Combinational digit-word to seven-segment decoder.
//   Ports:
//     word  in  5  bit4 = decimal point, bits3:0 = glyph value
//     sseg  out 8  active-low segments, sseg[7] = ~dp, sseg[6:0] = g..a
module sseg_decoder
   import stopwatch_disp_pkg::*;
(
   input  logic [4:0] word,
   output logic [7:0] sseg
);

   assign sseg = digit_to_sseg(digit_t'(word));

endmodule

// File: rtl/stopwatch_disp_scheduler.sv
// stopwatch_disp_scheduler
//   Scans six digit words onto a shared common-anode display. Inputs are
//   snapshotted once per frame so a frame never mixes old and new digits.
//   Supports leading-zero blanking and whole-display blinking.
//   Ports:
//     clk         in  1  system clock
//     rst_n       in  1  asynchronous active-low reset
//     in0..in5    in  5  digit words (in0 = rightmost digit)
//     blank_lz    in  1  blank leading zeros
//     blink_en    in  1  blink the whole display
//     an          out 6  active-low anode enables, an[k] = digit k
//     sseg        out 8  active-low segments {~dp, g..a}
//     frame_tick  out 1  one-cycle pulse at each frame start
module stopwatch_disp_scheduler
   import stopwatch_disp_pkg::*;
#(
   parameter int CLK_PER_DIGIT = 100000,
   parameter int BLINK_FRAMES  = 83
)(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [4:0] in0,
   input  logic [4:0] in1,
   input  logic [4:0] in2,
   input  logic [4:0] in3,
   input  logic [4:0] in4,
   input  logic [4:0] in5,
   input  logic       blank_lz,
   input  logic       blink_en,
   output logic [5:0] an,
   output logic [7:0] sseg,
   output logic       frame_tick
);

   localparam int               CNT_W    = (CLK_PER_DIGIT > 1) ? $clog2(CLK_PER_DIGIT) : 1;
   localparam int               BLK_W    = $clog2(BLINK_FRAMES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_PER_DIGIT - 1);
   localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);
   localparam logic [2:0]       SEL_LAST = 3'(NUM_DIGITS - 1);

   logic [CNT_W-1:0] cnt_reg;
   logic [2:0]       sel_reg;
   logic [BLK_W-1:0] blink_cnt_reg;
   logic             blink_phase_reg;
   logic [4:0]       shadow_reg [NUM_DIGITS];
   logic [4:0]       in_word    [NUM_DIGITS];

   logic             slot_end;
   logic             frame_start;
   logic             zero_run;
   logic [5:0]       blank_vec;
   logic [4:0]       cur_word;
   logic             cur_blank;
   logic [7:0]       cur_sseg;
   logic [5:0]       sel_onehot;
   logic [5:0]       an_next;

   assign in_word = '{in0, in1, in2, in3, in4, in5};

   assign slot_end    = (cnt_reg == CNT_LAST);
   assign frame_start = slot_end && (sel_reg == SEL_LAST);

   // Refresh counter, digit select and blink timebase.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg         <= '0;
         sel_reg         <= '0;
         blink_cnt_reg   <= '0;
         blink_phase_reg <= 1'b0;
      end else begin
         cnt_reg <= slot_end ? '0 : cnt_reg + 1'b1;
         if (slot_end)
            sel_reg <= (sel_reg == SEL_LAST) ? 3'd0 : sel_reg + 3'd1;
         if (frame_start) begin
            if (blink_cnt_reg == BLK_LAST) begin
               blink_cnt_reg   <= '0;
               blink_phase_reg <= ~blink_phase_reg;
            end else begin
               blink_cnt_reg <= blink_cnt_reg + 1'b1;
            end
         end
      end
   end

   // Frame snapshot: inputs are only sampled on the 5->0 wrap, so the
   // whole frame is drawn from one consistent set of digits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_DIGITS; i++)
            shadow_reg[i] <= '0;
      end else if (frame_start) begin
         for (int i = 0; i < NUM_DIGITS; i++)
            shadow_reg[i] <= in_word[i];
      end
   end

   // Leading-zero blanking: walk from the top digit down while every word
   // seen so far is entirely zero (a lone dp counts as content). Digit 0
   // is excluded so a zero reading still shows one "0".
   always_comb begin
      zero_run  = 1'b1;
      blank_vec = '0;
      for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
         zero_run     = zero_run && (shadow_reg[k] == 5'd0);
         blank_vec[k] = blank_lz && zero_run;
      end
   end

   always_comb begin
      cur_word  = shadow_reg[0];
      cur_blank = blank_vec[0];
      case (sel_reg)
         3'd1:    begin cur_word = shadow_reg[1]; cur_blank = blank_vec[1]; end
         3'd2:    begin cur_word = shadow_reg[2]; cur_blank = blank_vec[2]; end
         3'd3:    begin cur_word = shadow_reg[3]; cur_blank = blank_vec[3]; end
         3'd4:    begin cur_word = shadow_reg[4]; cur_blank = blank_vec[4]; end
         3'd5:    begin cur_word = shadow_reg[5]; cur_blank = blank_vec[5]; end
         default: ;
      endcase
   end

   sseg_decoder u_sseg_decoder (
      .word (cur_word),
      .sseg (cur_sseg)
   );

   // cnt==0 keeps all anodes off for one clock while the segment lines
   // settle on the new digit, which avoids ghosting into the neighbour.
   assign sel_onehot = 6'd1 << sel_reg;
   assign an_next    = ((cnt_reg == '0) || cur_blank || (blink_en && blink_phase_reg))
                       ? AN_OFF : ~sel_onehot;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         an         <= AN_OFF;
         sseg       <= SSEG_OFF;
         frame_tick <= 1'b0;
      end else begin
         an         <= an_next;
         sseg       <= cur_sseg;
         frame_tick <= frame_start;
      end
   end

endmodule

// File: tb/tb_stopwatch_disp_scheduler.sv
// tb_stopwatch_disp_scheduler
//   Directed bench for stopwatch_disp_scheduler with CLK_PER_DIGIT=4 and
//   BLINK_FRAMES=2. Each frame is captured cycle by cycle and compared
//   against hand-computed anode masks and segment patterns.
module tb_stopwatch_disp_scheduler;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] in0, in1, in2, in3, in4, in5;
   logic       blank_lz;
   logic       blink_en;
   logic [5:0] an;
   logic [7:0] sseg;
   logic       frame_tick;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] exp_sseg [6];

   stopwatch_disp_scheduler #(
      .CLK_PER_DIGIT (4),
      .BLINK_FRAMES  (2)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in0        (in0),
      .in1        (in1),
      .in2        (in2),
      .in3        (in3),
      .in4        (in4),
      .in5        (in5),
      .blank_lz   (blank_lz),
      .blink_en   (blink_en),
      .an         (an),
      .sseg       (sseg),
      .frame_tick (frame_tick)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic set_exp(input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] s2,
                          input logic [7:0] s3, input logic [7:0] s4, input logic [7:0] s5);
      exp_sseg = '{s0, s1, s2, s3, s4, s5};
   endtask

   // Captures one 24-clock frame starting at the cycle after a frame start
   // (or after reset release). shown[k]=1 means digit k is expected to light
   // for the last three clocks of its slot. Optionally rewrites in3 at
   // capture index mod_idx to probe tearing.
   task automatic check_frame(input string tag, input logic [5:0] shown,
                              input int mod_idx, input logic [4:0] mod_val);
      int         k;
      int         j;
      logic [5:0] one;
      logic [5:0] exp_an;
      one = 6'd1;
      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         k = i / 4;
         j = i % 4;
         exp_an = (j == 0 || !shown[k]) ? 6'h3F : ~(one << k);
         check_eq($sformatf("%s_an_s%0d_c%0d", tag, k, j), 32'(an), 32'(exp_an));
         check_eq($sformatf("%s_sseg_s%0d_c%0d", tag, k, j), 32'(sseg), 32'(exp_sseg[k]));
         check_eq($sformatf("%s_tick_i%0d", tag, i), 32'(frame_tick), 32'(i == 23));
         if (i == mod_idx) in3 = mod_val;
      end
      $display("frame %s checked (errors so far %0d)", tag, n_errors);
   endtask

   initial begin
      rst_n    = 1'b0;
      blank_lz = 1'b0;
      blink_en = 1'b0;
      in0 = 5'h00; in1 = 5'h01; in2 = 5'h02;
      in3 = 5'h03; in4 = 5'h04; in5 = 5'h05;
      repeat (3) @(negedge clk);
      check_eq("reset_an",   32'(an),         32'h3F);
      check_eq("reset_sseg", 32'(sseg),       32'hFF);
      check_eq("reset_tick", 32'(frame_tick), 32'h0);
      rst_n = 1'b1;

      // First frame shows the zeroed shadows.
      set_exp(8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0);
      check_frame("frame0", 6'h3F, -1, 5'h00);

      // Scan order with digits 0..5.
      set_exp(8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92);
      check_frame("scan", 6'h3F, -1, 5'h00);

      // in3 -> 8 while sel=1: this frame unchanged, next frame updated.
      check_frame("tear", 6'h3F, 5, 5'h08);
      set_exp(8'hC0, 8'hF9, 8'hA4, 8'h80, 8'h99, 8'h92);
      check_frame("tear_next", 6'h3F, -1, 5'h00);

      // Leading-zero blanking; current frame still uses old shadows.
      in0 = 5'h03; in1 = 5'h02; in2 = 5'h01; in3 = 5'h00; in4 = 5'h00; in5 = 5'h00;
      blank_lz = 1'b1;
      check_frame("lz_old", 6'h3F, -1, 5'h00);

      in5 = 5'h10;
      set_exp(8'hB0, 8'hA4, 8'hF9, 8'hC0, 8'hC0, 8'hC0);
      check_frame("lz", 6'h07, -1, 5'h00);

      in2 = 5'h15; in5 = 5'h00;
      set_exp(8'hB0, 8'hA4, 8'hF9, 8'hC0, 8'hC0, 8'h40);
      check_frame("lz_dp5", 6'h3F, -1, 5'h00);

      in2 = 5'h05;
      set_exp(8'hB0, 8'hA4, 8'h12, 8'hC0, 8'hC0, 8'hC0);
      check_frame("dp_on", 6'h07, -1, 5'h00);

      set_exp(8'hB0, 8'hA4, 8'h92, 8'hC0, 8'hC0, 8'hC0);
      check_frame("dp_off", 6'h07, -1, 5'h00);

      // Blink: frames since reset 9..12 -> phase 0,1,1,0.
      blank_lz = 1'b0;
      blink_en = 1'b1;
      check_frame("blink9",  6'h3F, -1, 5'h00);
      check_frame("blink10", 6'h00, -1, 5'h00);
      check_frame("blink11", 6'h00, -1, 5'h00);
      check_frame("blink12", 6'h3F, -1, 5'h00);

      // blink_en=0: frame 14 has phase 1 but must still be lit.
      blink_en = 1'b0;
      check_frame("noblink13", 6'h3F, -1, 5'h00);
      check_frame("noblink14", 6'h3F, -1, 5'h00);

      // Async reset in slot 4, cnt=2.
      repeat (18) @(negedge clk);
      check_eq("pre_rst_an", 32'(an), 32'h2F);
      #1 rst_n = 1'b0;
      #1;
      check_eq("mid_rst_an",   32'(an),         32'h3F);
      check_eq("mid_rst_sseg", 32'(sseg),       32'hFF);
      check_eq("mid_rst_tick", 32'(frame_tick), 32'h0);
      #2 rst_n = 1'b1;

      set_exp(8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0);
      check_frame("after_rst", 6'h3F, -1, 5'h00);
      set_exp(8'hB0, 8'hA4, 8'h92, 8'hC0, 8'hC0, 8'hC0);
      check_frame("after_rst_next", 6'h3F, -1, 5'h00);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
